vmem_arbiter: RTL and testbench

- Shares the single frame-buffer memory controller command port between two requesters.
- Video read requester: the per-line burst read generator feeding the display FIFO.
- Write requester: the USB-side frame-buffer update path.
- Sequences each command handshake and the write-data beats of write bursts. Reads get priority, and a starvation counter guarantees write progress.

---
 rtl/vmem_arbiter.sv | 149 ++++++++++++++
 tb/tb_vmem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vmem_arbiter.sv
// vmem_arbiter: shares the frame-buffer controller command port between the video read
// path (priority) and the USB write path. Define ARB_STATS_EN to add grant counters.
module vmem_arbiter #(
  parameter int ADDR_W        = 25,
  parameter int DATA_W        = 16,
  parameter int BURST_LEN     = 8,
  parameter int WR_STARVE_MAX = 4
) (
  input  logic              mem_clock,
  input  logic              reset,
  input  logic              mem_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              wr_ack,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_data_rd,
  output logic              cmd_valid,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_ack,
  input  logic              cmd_wdata_req,
  output logic [DATA_W-1:0] cmd_wdata
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       rd_grant_cnt,
  output logic [15:0]       wr_grant_cnt
`endif
);

  localparam int BEAT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int STARVE_W = $clog2(WR_STARVE_MAX + 1);
  localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(WR_STARVE_MAX);

  typedef enum logic [1:0] {IDLE, RD_CMD, WR_CMD, WR_DATA} state_t;

  state_t              r_state, w_next_state;
  logic                r_cmd_valid, w_next_valid;
  logic                r_cmd_write, w_next_write;
  logic [ADDR_W-1:0]   r_cmd_addr, w_next_addr;
  logic [BEAT_W-1:0]   r_beat_cnt, w_next_beat;
  logic [STARVE_W-1:0] r_starve_cnt, w_next_starve;
  logic                w_wr_wins;

  always_ff @(posedge mem_clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cmd_valid  <= 1'b0;
      r_cmd_write  <= 1'b0;
      r_cmd_addr   <= '0;
      r_beat_cnt   <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_next_state;
      r_cmd_valid  <= w_next_valid;
      r_cmd_write  <= w_next_write;
      r_cmd_addr   <= w_next_addr;
      r_beat_cnt   <= w_next_beat;
      r_starve_cnt <= w_next_starve;
    end
  end

  // Writes only beat a pending read once reads have starved them WR_STARVE_MAX times.
  always_comb begin
    w_next_state  = r_state;
    w_next_valid  = r_cmd_valid;
    w_next_write  = r_cmd_write;
    w_next_addr   = r_cmd_addr;
    w_next_beat   = r_beat_cnt;
    w_next_starve = r_starve_cnt;
    rd_ack        = 1'b0;
    wr_ack        = 1'b0;
    wr_data_rd    = 1'b0;
    cmd_wdata     = '0;
    w_wr_wins     = wr_req && (!rd_req || (r_starve_cnt == STARVE_MAX));
    case (r_state)
      IDLE: begin
        if (mem_ready) begin
          if (w_wr_wins) begin
            w_next_state  = WR_CMD;
            w_next_valid  = 1'b1;
            w_next_write  = 1'b1;
            w_next_addr   = wr_addr;
            w_next_starve = '0;
          end else if (rd_req) begin
            w_next_state = RD_CMD;
            w_next_valid = 1'b1;
            w_next_write = 1'b0;
            w_next_addr  = rd_addr;
            if (wr_req && (r_starve_cnt != STARVE_MAX)) begin
              w_next_starve = r_starve_cnt + 1'b1;
            end
          end
        end
      end
      RD_CMD: begin
        rd_ack = cmd_ack;
        if (cmd_ack) begin
          w_next_valid = 1'b0;
          w_next_state = IDLE;
        end
      end
      WR_CMD: begin
        wr_ack = cmd_ack;
        if (cmd_ack) begin
          w_next_valid = 1'b0;
          w_next_beat  = '0;
          w_next_state = WR_DATA;
        end
      end
      WR_DATA: begin
        cmd_wdata  = wr_data;
        wr_data_rd = cmd_wdata_req;
        if (cmd_wdata_req) begin
          w_next_beat = r_beat_cnt + 1'b1;
          if (r_beat_cnt == LAST_BEAT) begin
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_write = r_cmd_write;
  assign cmd_addr  = r_cmd_addr;

`ifdef ARB_STATS_EN
  logic [15:0] r_rd_grant_cnt, r_wr_grant_cnt;

  always_ff @(posedge mem_clock or posedge reset) begin
    if (reset) begin
      r_rd_grant_cnt <= '0;
      r_wr_grant_cnt <= '0;
    end else begin
      if (rd_ack && (r_rd_grant_cnt != 16'hFFFF)) r_rd_grant_cnt <= r_rd_grant_cnt + 16'd1;
      if (wr_ack && (r_wr_grant_cnt != 16'hFFFF)) r_wr_grant_cnt <= r_wr_grant_cnt + 16'd1;
    end
  end

  assign rd_grant_cnt = r_rd_grant_cnt;
  assign wr_grant_cnt = r_wr_grant_cnt;
`endif

endmodule

// File: tb/tb_vmem_arbiter.sv
// Testbench for vmem_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of the arbitration rules.
module tb_vmem_arbiter;
  localparam int ADDR_W        = 25;
  localparam int DATA_W        = 16;
  localparam int BURST_LEN     = 8;
  localparam int WR_STARVE_MAX = 4;

  logic              mem_clock = 1'b0;
  logic              reset = 1'b1;
  logic              mem_ready = 1'b0;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_ack;
  logic              wr_req = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic              wr_ack;
  logic [DATA_W-1:0] wr_data = 16'h1234;
  logic              wr_data_rd;
  logic              cmd_valid;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_ack = 1'b0;
  logic              cmd_wdata_req = 1'b0;
  logic [DATA_W-1:0] cmd_wdata;
`ifdef ARB_STATS_EN
  logic [15:0]       rd_grant_cnt;
  logic [15:0]       wr_grant_cnt;
`endif

  vmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .WR_STARVE_MAX(WR_STARVE_MAX)
  ) dut (
    .mem_clock(mem_clock), .reset(reset), .mem_ready(mem_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack),
    .wr_data(wr_data), .wr_data_rd(wr_data_rd),
    .cmd_valid(cmd_valid), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_ack(cmd_ack), .cmd_wdata_req(cmd_wdata_req), .cmd_wdata(cmd_wdata)
`ifdef ARB_STATS_EN
    , .rd_grant_cnt(rd_grant_cnt), .wr_grant_cnt(wr_grant_cnt)
`endif
  );

  always #5 mem_clock = ~mem_clock;

  int checks = 0;
  int errors = 0;

  // Stimulus behaviour: requester modes 0 hold+advance, 1 drop on ack, 2 random,
  // 3 jitter address while granted, 4 idle. Data-request modes 0 always, 1 alternate, 2 random, 3 off.
  int rdMode = 4, wrMode = 4, wdMode = 3;
  bit ackRandom = 0;
  int ackFixed = 0, ackDelay = 0, ackWait = 0;
  bit wdToggle = 0;
  bit sawRdAck = 0, sawWrAck = 0, sawWdRd = 0;

  // Transaction-level reference model.
  bit                mBusy = 0, mCmdOut = 0, mIsWrite = 0, mWrite = 0;
  logic [ADDR_W-1:0] mAddr = '0;
  int                mBeatsLeft = 0, mStarve = 0, mRdStat = 0, mWrStat = 0;

  int   rdAckTot = 0, wrAckTot = 0, wdRdTot = 0, validTot = 0;
  bit   prevValid = 0;
  byte  grantLog[$];
  logic [ADDR_W-1:0] lastGrantAddr = '0;

  task automatic checkVal(input string name, input logic [31:0] actVal, input logic [31:0] reqVal);
    checks++;
    if (actVal !== reqVal) begin
      errors++;
      $display("[TB] FAIL %s at %0t: actual=0x%0h required=0x%0h", name, $time, actVal, reqVal);
    end
  endtask

  task automatic applyStimulus();
    @(posedge mem_clock);
    #1;
    if (cmd_valid) begin
      if (ackWait == 0) ackDelay = ackRandom ? int'($urandom_range(0, 3)) : ackFixed;
      cmd_ack = (ackWait == ackDelay);
      ackWait++;
    end else begin
      cmd_ack = 1'b0;
      ackWait = 0;
    end
    wdToggle = ~wdToggle;
    case (wdMode)
      0: cmd_wdata_req = 1'b1;
      1: cmd_wdata_req = wdToggle;
      2: cmd_wdata_req = ($urandom_range(0, 1) == 1);
      default: cmd_wdata_req = 1'b0;
    endcase
    if (sawWdRd) wr_data = DATA_W'($urandom);
    case (rdMode)
      0: if (sawRdAck) rd_addr = rd_addr + 1'b1;
      1: if (sawRdAck) rd_req = 1'b0;
      2: if (sawRdAck || (!rd_req && $urandom_range(0, 3) == 0)) begin
           rd_req  = ($urandom_range(0, 2) != 0);
           rd_addr = ADDR_W'($urandom);
         end
      3: if (sawRdAck) rd_req = 1'b0;
         else if (cmd_valid && !cmd_write) rd_addr = ADDR_W'($urandom);
      default: rd_req = 1'b0;
    endcase
    case (wrMode)
      0: if (sawWrAck) wr_addr = wr_addr + 1'b1;
      1: if (sawWrAck) wr_req = 1'b0;
      2: if (sawWrAck || (!wr_req && $urandom_range(0, 3) == 0)) begin
           wr_req  = ($urandom_range(0, 2) != 0);
           wr_addr = ADDR_W'($urandom);
         end
      default: wr_req = 1'b0;
    endcase
  endtask

  task automatic checkOutput();
    bit eValid, eRdAck, eWrAck, eWdRd, inBurst, wrWins;
    logic [DATA_W-1:0] eWdata;
    @(negedge mem_clock);
    if (reset) begin
      mBusy = 0; mCmdOut = 0; mIsWrite = 0; mWrite = 0; mAddr = '0;
      mBeatsLeft = 0; mStarve = 0; mRdStat = 0; mWrStat = 0;
    end
    eValid  = mBusy && mCmdOut;
    inBurst = mBusy && !mCmdOut;
    eRdAck  = eValid && !mIsWrite && cmd_ack;
    eWrAck  = eValid && mIsWrite && cmd_ack;
    eWdRd   = inBurst && cmd_wdata_req;
    eWdata  = inBurst ? wr_data : '0;
    checkVal("cmd_valid", 32'(cmd_valid), 32'(eValid));
    checkVal("cmd_write", 32'(cmd_write), 32'(mWrite));
    checkVal("cmd_addr", 32'(cmd_addr), 32'(mAddr));
    checkVal("rd_ack", 32'(rd_ack), 32'(eRdAck));
    checkVal("wr_ack", 32'(wr_ack), 32'(eWrAck));
    checkVal("wr_data_rd", 32'(wr_data_rd), 32'(eWdRd));
    checkVal("cmd_wdata", 32'(cmd_wdata), 32'(eWdata));
`ifdef ARB_STATS_EN
    checkVal("rd_grant_cnt", 32'(rd_grant_cnt), 32'(mRdStat));
    checkVal("wr_grant_cnt", 32'(wr_grant_cnt), 32'(mWrStat));
    if (eRdAck && mRdStat < 65535) mRdStat++;
    if (eWrAck && mWrStat < 65535) mWrStat++;
`endif
    sawRdAck = rd_ack;
    sawWrAck = wr_ack;
    sawWdRd  = wr_data_rd;
    if (rd_ack) rdAckTot++;
    if (wr_ack) wrAckTot++;
    if (wr_data_rd) wdRdTot++;
    if (cmd_valid) validTot++;
    if (cmd_valid && !prevValid) begin
      grantLog.push_back(cmd_write ? 8'h57 : 8'h52);
      lastGrantAddr = cmd_addr;
    end
    prevValid = cmd_valid;
    if (!reset) begin
      if (!mBusy) begin
        if (mem_ready) begin
          wrWins = wr_req && (!rd_req || mStarve == WR_STARVE_MAX);
          if (wrWins) begin
            mBusy = 1; mCmdOut = 1; mIsWrite = 1; mWrite = 1; mAddr = wr_addr;
            mStarve = 0; mBeatsLeft = BURST_LEN;
          end else if (rd_req) begin
            mBusy = 1; mCmdOut = 1; mIsWrite = 0; mWrite = 0; mAddr = rd_addr;
            if (wr_req && mStarve < WR_STARVE_MAX) mStarve++;
          end
        end
      end else if (mCmdOut) begin
        if (cmd_ack) begin
          mCmdOut = 0;
          if (!mIsWrite) mBusy = 0;
        end
      end else if (cmd_wdata_req) begin
        mBeatsLeft--;
        if (mBeatsLeft == 0) mBusy = 0;
      end
    end
  endtask

  task automatic cycle();
    applyStimulus();
    checkOutput();
  endtask

  task automatic releaseReset();
    checkOutput();
    cycle();
    applyStimulus();
    reset = 1'b0;
    checkOutput();
  endtask

  initial begin
    string expSeq;
    int snapA, snapB, snapC, budget, badAddr;

    // Reset with both requests pending and the controller not ready.
    rdMode = 0; wrMode = 0; wdMode = 0; ackFixed = 0;
    rd_req = 1'b1; rd_addr = 25'h0000100;
    wr_req = 1'b1; wr_addr = 25'h0000200;
    repeat (3) cycle();
    applyStimulus();
    reset = 1'b0;
    checkOutput();
    snapA = validTot;
    repeat (10) cycle();
    checkVal("noCmdBeforeReady", 32'(validTot - snapA), 32'd0);
    applyStimulus();
    mem_ready = 1'b1;
    checkOutput();
    cycle();
    checkVal("firstGrantValid", 32'(cmd_valid), 32'd1);
    checkVal("firstGrantWrite", 32'(cmd_write), 32'd0);
    checkVal("firstGrantAddr", 32'(cmd_addr), 32'h0000100);

    // Continuous reads and writes: starvation counter forces every fifth grant.
    budget = 400;
    while (grantLog.size() < 10 && budget > 0) begin
      cycle();
      budget--;
    end
    checkVal("grantCount", 32'(grantLog.size() >= 10), 32'd1);
    expSeq = "RRRRWRRRRW";
    for (int i = 0; i < 10; i++) begin
      if (i < grantLog.size()) checkVal($sformatf("grantSeq%0d", i), 32'(grantLog[i]), 32'(expSeq[i]));
    end

    // Single write burst with spaced data requests.
    applyStimulus();
    reset = 1'b1;
    rdMode = 4; rd_req = 1'b0;
    wrMode = 1; wr_req = 1'b1; wr_addr = 25'h0001240;
    wdMode = 1;
    releaseReset();
    snapA = wrAckTot; snapB = wdRdTot; snapC = rdAckTot;
    repeat (60) cycle();
    checkVal("wrBurstAck", 32'(wrAckTot - snapA), 32'd1);
    checkVal("wrBurstBeats", 32'(wdRdTot - snapB), 32'd8);
    checkVal("wrBurstNoRead", 32'(rdAckTot - snapC), 32'd0);
    checkVal("wrBurstAddr", 32'(lastGrantAddr), 32'h0001240);
    checkVal("wrBurstIdle", 32'(cmd_valid), 32'd0);
`ifdef ARB_STATS_EN
    checkVal("statWr", 32'(wr_grant_cnt), 32'd1);
    checkVal("statRd", 32'(rd_grant_cnt), 32'd0);
`endif

    // Delayed cmd_ack while the requester address wanders after grant.
    applyStimulus();
    reset = 1'b1;
    rdMode = 3; rd_req = 1'b1; rd_addr = 25'h0ABCDEF;
    wrMode = 4; wr_req = 1'b0;
    wdMode = 3; ackFixed = 5;
    releaseReset();
    snapA = rdAckTot; snapB = validTot; badAddr = 0;
    repeat (30) begin
      cycle();
      if (cmd_valid && cmd_addr != 25'h0ABCDEF) badAddr++;
    end
    checkVal("slowAckRdAck", 32'(rdAckTot - snapA), 32'd1);
    checkVal("slowAckValidCycles", 32'(validTot - snapB), 32'd6);
    checkVal("slowAckAddrHeld", 32'(badAddr), 32'd0);

    // Reset in the middle of a write burst, then a fresh burst.
    applyStimulus();
    reset = 1'b1;
    rdMode = 4; rd_req = 1'b0;
    wrMode = 1; wr_req = 1'b1; wr_addr = 25'h0000333;
    wdMode = 0; ackFixed = 0;
    releaseReset();
    snapB = wdRdTot;
    budget = 50;
    while ((wdRdTot - snapB) < 3 && budget > 0) begin
      cycle();
      budget--;
    end
    checkVal("midBurstBeats", 32'(wdRdTot - snapB), 32'd3);
    applyStimulus();
    reset = 1'b1;
    wr_req = 1'b1; wr_addr = 25'h0000444;
    checkOutput();
    checkVal("midRstValid", 32'(cmd_valid), 32'd0);
    checkVal("midRstDataRd", 32'(wr_data_rd), 32'd0);
    checkVal("midRstWdata", 32'(cmd_wdata), 32'd0);
    checkVal("midRstAddr", 32'(cmd_addr), 32'd0);
    cycle();
    applyStimulus();
    reset = 1'b0;
    checkOutput();
    snapA = wrAckTot; snapB = wdRdTot;
    repeat (40) cycle();
    checkVal("postRstAck", 32'(wrAckTot - snapA), 32'd1);
    checkVal("postRstBeats", 32'(wdRdTot - snapB), 32'd8);
    checkVal("postRstAddr", 32'(lastGrantAddr), 32'h0000444);

    // Randomized traffic with random ack latency, readiness and occasional resets.
    rdMode = 2; wrMode = 2; wdMode = 2; ackRandom = 1;
    repeat (4000) begin
      applyStimulus();
      reset = ($urandom_range(0, 499) == 0);
      mem_ready = ($urandom_range(0, 9) != 0);
      checkOutput();
    end
    checkVal("randomTrafficReads", 32'(rdAckTot > 20), 32'd1);
    checkVal("randomTrafficWrites", 32'(wrAckTot > 20), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
